fir_lane_serializer: RTL and testbench
======================================

// Module: fir_lane_serializer
// PURPOSE
//  Output back end for the 3-lane parallel FIR filter. Captures one frame of LANES
//  wide accumulator results on a strobe, rounds and saturates each to DATA_W, and
//  emits them one sample per beat on a valid/ready stream, lane 0 first.
//  Double-buffered so a new frame can be captured while the previous one drains.
//  Provides overflow and saturation statistics for system monitoring.
// PARAMETERS
//  DATA_W      24   output sample width, signed
//  ACC_W       48   lane accumulator width, signed
//  LANES       3    lanes per frame
//  FRAC_SHIFT  23   coefficient fraction bits (Q1.23); result = acc >>> FRAC_SHIFT, rounded
// PORTS
//  clk            in   1             single clock, rising edge
//  reset_n        in   1             asynchronous, active-low reset
//  frame_valid    in   1             one-cycle strobe: lane_acc holds a complete frame
//  lane_acc       in   LANES*ACC_W   lane i at [i*ACC_W +: ACC_W], signed
//  frame_ready    out  1             a buffer slot is free (registered)
//  out_data       out  DATA_W        rounded/saturated sample
//  out_lane       out  2             lane index of out_data
//  out_last       out  1             high on the beat carrying lane LANES-1
//  out_valid      out  1             out_data valid
//  out_ready      in   1             downstream accepts beat when out_valid & out_ready
//  clear_stats    in   1             synchronous clear of overflow_sticky and sat_count
//  overflow_sticky out 1             a frame was offered while frame_ready=0
//  sat_count      out  16            lanes saturated since last clear, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0 except frame_ready=1; both slots empty; FSM IDLE; lane ptr 0.
//  - Capture: when frame_valid & frame_ready, every lane is rounded and saturated, then
//    stored as DATA_W in the write slot. Round = add 2^(FRAC_SHIFT-1), arithmetic shift
//    right FRAC_SHIFT (round half toward +inf). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  - frame_ready = (slots_used < 2), from registered state only; no combinational
//    path from out_ready. A slot freed in cycle N raises frame_ready at N+1.
//  - frame_valid while frame_ready=0: frame dropped, overflow_sticky set, buffer untouched.
//  - FSM: IDLE -> EMIT once a slot is full. EMIT presents lane ptr of read slot;
//    on a handshake ptr++. On the handshake with ptr=LANES-1: release slot, ptr=0, and
//    go to IDLE if the other slot is empty, else stay in EMIT (next frame, no bubble).
//  - Latency: capture at edge N -> out_valid for lane 0 at N+1 if FSM was IDLE.
//  - While out_valid & !out_ready: out_data/out_lane/out_last held stable.
//  - Capture and final-lane handshake in the same cycle: both take effect; slots_used unchanged.
//  - sat_count += number of lanes saturated in captured frame, clamped at 16'hFFFF.
//  - clear_stats has priority over same-cycle overflow/saturation updates (result 0).
//  - Reset mid-frame: partial frame discarded, return to reset state immediately.
//  - Full rate: out_ready=1 and one frame per LANES cycles -> no drops, out_valid continuous.
// STRUCTURE
//  - Shared package fir_pkg: DATA_W, ACC_W, LANES, FRAC_SHIFT constants; state encoding
//    typedef (IDLE, EMIT); SAT_MAX/SAT_MIN constants.
//  - Sub-module fir_round_sat (combinational, ACC_W in -> DATA_W out + sat flag),
//    instantiated LANES times on the capture path.
//  - Top: 2 x LANES x DATA_W slot storage, wr/rd slot bits, slots_used, FSM, stats.
// TESTING
//  1. Single frame, out_ready=1: acc = {3<<23, 48'h400000, -48'h400000} -> beats 3, 1, 0;
//     lanes 0,1,2; out_last on beat 3 only; sat_count=0.
//  2. Saturation: acc = {48'h7FFFFF000000, -48'h7FFFFF000000, 0} -> 24'h7FFFFF,
//     24'h800000, 0; sat_count=2.
//  3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_lane stable,
//     all 3 beats later delivered in order, no loss.
//  4. Overflow: out_ready=0, strobe 3 frames -> frames 1,2 accepted, frame_ready=0,
//     overflow_sticky=1; after out_ready=1 exactly 6 beats (frames 1,2) emitted.
//  5. clear_stats asserted in the same cycle as a saturating capture -> sat_count=0,
//     overflow_sticky=0 next cycle.
//  6. reset_n low during beat 2 of a frame -> out_valid=0, frame_ready=1 asynchronously;
//     after release, next frame emits from lane 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR lane serializer back end.
// Sample/accumulator widths, lane count, rounding shift, saturation limits, FSM encoding.
package fir_pkg;

  localparam int DATA_W     = 24;
  localparam int ACC_W      = 48;
  localparam int LANES      = 3;
  localparam int FRAC_SHIFT = 23;

  // Width able to hold a count of 0..LANES saturated lanes.
  localparam int SATN_W = $clog2(LANES + 1);

  localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up of a Q-format accumulator to DATA_W with saturation.
// Zero latency; no flow control.
module fir_round_sat
  import fir_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] data,
  output logic              sat
);

  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W+1-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shr;
  logic [ACC_W-DATA_W+1:0] upper;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign ext   = {acc[ACC_W-1], acc};
  assign sum   = ext + RND;
  assign shr   = sum >>> FRAC_SHIFT;
  assign upper = shr[ACC_W:DATA_W-1];

  // In range only when everything above the output MSB is pure sign extension.
  assign sat  = !((&upper) || (~|upper));
  assign data = sat ? (shr[ACC_W] ? SAT_MIN : SAT_MAX) : shr[DATA_W-1:0];

endmodule

// File: rtl/fir_lane_serializer.sv
// Captures a LANES-wide frame into one of two slots and streams samples lane 0 first.
// First beat valid the cycle after capture; out_ready stalls hold the beat; frame_ready drops with both slots full.
module fir_lane_serializer
  import fir_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_valid,
  input  logic [LANES*ACC_W-1:0] lane_acc,
  output logic                   frame_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             out_lane,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear_stats,
  output logic                   overflow_sticky,
  output logic [15:0]            sat_count
);

  logic [DATA_W-1:0] rnd_data [LANES];
  logic [LANES-1:0]  rnd_sat;
  logic [DATA_W-1:0] slot_mem [2][LANES];

  logic              wr_slot;
  logic              rd_slot;
  logic [1:0]        slots_used;
  state_t            state;
  logic [1:0]        ptr;

  logic              capture;
  logic              handshake;
  logic              release_slot;
  logic              more_pending;
  logic [SATN_W-1:0] sat_n;
  logic [16:0]       sat_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fir_round_sat u_round_sat (
      .acc  (lane_acc[i*ACC_W +: ACC_W]),
      .data (rnd_data[i]),
      .sat  (rnd_sat[i])
    );
  end

  assign frame_ready  = (slots_used < 2'd2);
  assign capture      = frame_valid & frame_ready;
  assign handshake    = out_valid & out_ready;
  assign release_slot = handshake & (ptr == LAST_LANE);
  // The next frame is either already stored or landing in the other slot this very cycle.
  assign more_pending = (slots_used == 2'd2) | capture;

  assign out_lane = ptr;
  assign out_data = out_valid ? slot_mem[rd_slot][ptr] : '0;

  always_comb begin
    sat_n = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_n = sat_n + SATN_W'(rnd_sat[i]);
    end
  end

  assign sat_sum = {1'b0, sat_count} + 17'(sat_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int l = 0; l < LANES; l++) begin
          slot_mem[s][l] <= '0;
        end
      end
      wr_slot <= 1'b0;
    end else if (capture) begin
      for (int l = 0; l < LANES; l++) begin
        slot_mem[wr_slot][l] <= rnd_data[l];
      end
      wr_slot <= ~wr_slot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slots_used <= 2'd0;
    end else if (capture && !release_slot) begin
      slots_used <= slots_used + 2'd1;
    end else if (!capture && release_slot) begin
      slots_used <= slots_used - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      rd_slot   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            state     <= ST_EMIT;
            out_valid <= 1'b1;
            ptr       <= 2'd0;
            out_last  <= (LAST_LANE == 2'd0);
          end
        end
        ST_EMIT: begin
          if (handshake) begin
            if (ptr == LAST_LANE) begin
              ptr      <= 2'd0;
              rd_slot  <= ~rd_slot;
              out_last <= (LAST_LANE == 2'd0);
              if (!more_pending) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              ptr      <= ptr + 2'd1;
              out_last <= ((ptr + 2'd1) == LAST_LANE);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clearing wins over any same-cycle overflow or saturation event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_sticky <= 1'b0;
      sat_count       <= 16'd0;
    end else if (clear_stats) begin
      overflow_sticky <= 1'b0;
      sat_count       <= 16'd0;
    end else begin
      if (frame_valid && !frame_ready) begin
        overflow_sticky <= 1'b1;
      end
      if (capture) begin
        sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_fir_lane_serializer.sv
// Randomised and directed bench for fir_lane_serializer against a queue-based frame model.
module tb_fir_lane_serializer;

  logic         clk;
  logic         reset_n;
  logic         frame_valid;
  logic [143:0] lane_acc;
  logic         frame_ready;
  logic [23:0]  out_data;
  logic [1:0]   out_lane;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic         clear_stats;
  logic         overflow_sticky;
  logic [15:0]  sat_count;

  fir_lane_serializer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_valid     (frame_valid),
    .lane_acc        (lane_acc),
    .frame_ready     (frame_ready),
    .out_data        (out_data),
    .out_lane        (out_lane),
    .out_last        (out_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .clear_stats     (clear_stats),
    .overflow_sticky (overflow_sticky),
    .sat_count       (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int hs_seen  = 0;

  logic [23:0] q_d[$];
  int          q_l[$];
  int          exp_sat = 0;
  bit          exp_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value/2^23 rounded half up, clamped to signed 24 bits.
  function automatic logic [23:0] ref_rs(input logic [47:0] a, output bit s);
    longint v;
    longint r;
    v = {{16{a[47]}}, a};
    r = (v + 64'sd4194304) >>> 23;
    s = 1'b0;
    if (r > 64'sd8388607) begin
      s = 1'b1;
      return 24'h7FFFFF;
    end
    if (r < -64'sd8388608) begin
      s = 1'b1;
      return 24'h800000;
    end
    return r[23:0];
  endfunction

  function automatic logic [47:0] rand_acc();
    longint v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: v = (longint'($urandom_range(0, 33554431)) - 64'sd16777216) * 64'sd8388608
             + ($urandom_range(0, 1) ? 64'sd4194304 : longint'($urandom_range(0, 8388607)));
      default: v = longint'($urandom_range(0, 2147483647)) - 64'sd1073741824;
    endcase
    return v[47:0];
  endfunction

  // Compare this cycle's outputs with the model, then advance both across one edge.
  task automatic tick();
    bit          ev;
    bit          efr;
    bit          acc_ok;
    bit          hs;
    bit          s;
    int          nsat;
    logic [23:0] d[3];
    ev  = (q_d.size() > 0);
    efr = (((q_d.size() + 2) / 3) < 2);
    check_val("frame_ready", frame_ready, efr);
    check_val("out_valid", out_valid, ev);
    if (ev) begin
      check_val("out_data", out_data, q_d[0]);
      check_val("out_lane", out_lane, q_l[0]);
      check_val("out_last", out_last, (q_l[0] == 2));
    end
    check_val("overflow_sticky", overflow_sticky, exp_ovf);
    check_val("sat_count", sat_count, exp_sat);
    acc_ok = frame_valid && efr;
    hs     = ev && out_ready;
    if (out_valid && out_ready) hs_seen++;
    nsat = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = ref_rs(lane_acc[i*48 +: 48], s);
      nsat += int'(s);
    end
    @(posedge clk);
    if (hs) begin
      void'(q_d.pop_front());
      void'(q_l.pop_front());
    end
    if (acc_ok) begin
      for (int i = 0; i < 3; i++) begin
        q_d.push_back(d[i]);
        q_l.push_back(i);
      end
    end
    if (clear_stats) begin
      exp_sat = 0;
      exp_ovf = 1'b0;
    end else begin
      if (frame_valid && !efr) exp_ovf = 1'b1;
      if (acc_ok) exp_sat = (exp_sat + nsat > 65535) ? 65535 : exp_sat + nsat;
    end
    #1;
  endtask

  task automatic send(input logic [47:0] a0, input logic [47:0] a1, input logic [47:0] a2);
    frame_valid = 1'b1;
    lane_acc    = {a2, a1, a0};
    tick();
    frame_valid = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    lane_acc    = '0;
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_frame_ready", frame_ready, 1'b1);
    check_val("rst_out_data", out_data, 24'd0);
    check_val("rst_out_lane", out_lane, 2'd0);
    check_val("rst_out_last", out_last, 1'b0);
    check_val("rst_overflow", overflow_sticky, 1'b0);
    check_val("rst_sat_count", sat_count, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic frame, rounding including the +/-0.5 cases.
    out_ready = 1'b1;
    send(48'd25165824, 48'h400000, -48'h400000);
    check_val("t1_beat0", out_data, 24'd3);
    tick();
    check_val("t1_beat1", out_data, 24'd1);
    tick();
    check_val("t1_beat2", out_data, 24'd0);
    check_val("t1_last", out_last, 1'b1);
    tick();
    check_val("t1_sat", sat_count, 16'd0);

    // Saturation at both rails.
    send(48'h7FFFFF000000, -48'h7FFFFF000000, 48'd0);
    check_val("t2_beat0", out_data, 24'h7FFFFF);
    tick();
    check_val("t2_beat1", out_data, 24'h800000);
    repeat (2) tick();
    check_val("t2_sat", sat_count, 16'd2);

    // Backpressure hold.
    out_ready = 1'b0;
    send(rand_acc(), rand_acc(), rand_acc());
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // Overflow: third back-to-back frame must be dropped.
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) send(rand_acc(), rand_acc(), rand_acc());
    tick();
    check_val("t4_frame_ready", frame_ready, 1'b0);
    check_val("t4_overflow", overflow_sticky, 1'b1);
    hs_seen   = 0;
    out_ready = 1'b1;
    repeat (8) tick();
    check_val("t4_beats", hs_seen, 6);

    // Clear beats a same-cycle saturating capture.
    clear_stats = 1'b1;
    send(48'h7FFFFF000000, 48'h7FFFFF000000, 48'd0);
    clear_stats = 1'b0;
    check_val("t5_sat", sat_count, 16'd0);
    check_val("t5_overflow", overflow_sticky, 1'b0);
    repeat (4) tick();

    // Reset in the middle of a frame.
    send(rand_acc(), rand_acc(), rand_acc());
    tick();
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_out_valid", out_valid, 1'b0);
    check_val("t6_frame_ready", frame_ready, 1'b1);
    check_val("t6_out_lane", out_lane, 2'd0);
    q_d.delete();
    q_l.delete();
    exp_sat = 0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(48'd16777216, 48'd0, 48'd0);
    check_val("t6_first_lane", out_lane, 2'd0);
    check_val("t6_first_data", out_data, 24'd2);
    repeat (3) tick();

    // Full rate: one frame every three cycles.
    out_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      send(rand_acc(), rand_acc(), rand_acc());
      repeat (2) tick();
    end
    check_val("fr_overflow", overflow_sticky, 1'b0);
    repeat (4) tick();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      frame_valid = ($urandom_range(0, 2) == 0);
      lane_acc    = {rand_acc(), rand_acc(), rand_acc()};
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_stats = ($urandom_range(0, 50) == 0);
      tick();
    end
    frame_valid = 1'b0;
    clear_stats = 1'b0;
    out_ready   = 1'b1;
    repeat (8) tick();
    check_val("end_drained", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
